// File: rtl/stopwatch_bcd.sv
// MM:SS.t BCD stopwatch counting prescaler ticks; optional lap hold via STOPWATCH_LAP_EN.
// Latency: 1 clk from tick/control pulse to disp/flags.
// Backpressure: none, every tick and control pulse is consumed on the edge it arrives.
module stopwatch_bcd #(
    parameter bit WRAP    = 1'b1,
    parameter int MAX_MIN = 59
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [19:0] disp,
    output logic        running,
    output logic        ovf,
    output logic        frozen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] MT_MAX = 4'(MAX_MIN / 10);
    localparam logic [3:0] MU_MAX = 4'(MAX_MIN % 10);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_mt, r_mu, r_st, r_su, r_t;
    logic        r_running;
    logic        r_ovf;
    logic [19:0] w_live;
    logic        w_adv, w_c0, w_c1, w_c2, w_c3, w_terminal, w_sat, w_zero;

    // Ripple-enable carry chain; each stage only advances when all lower stages wrap.
    assign w_adv      = (r_state == S_RUN) && tick;
    assign w_c0       = (r_t == 4'd9);
    assign w_c1       = w_c0 && (r_su == 4'd9);
    assign w_c2       = w_c1 && (r_st == 4'd5);
    assign w_c3       = w_c2 && (r_mu == 4'd9);
    assign w_terminal = w_c2 && (r_mt == MT_MAX) && (r_mu == MU_MAX);
    assign w_sat      = w_adv && w_terminal && !WRAP;
    assign w_zero     = (r_state == S_PAUSE) && clear;
    assign w_live     = {r_mt, r_mu, r_st, r_su, r_t};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_stop) w_state_nxt = S_RUN;
            S_RUN:   if (start_stop || w_sat) w_state_nxt = S_PAUSE;
            S_PAUSE: begin
                if (clear) w_state_nxt = S_IDLE;
                else if (start_stop && !r_ovf) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mt <= 4'd0; r_mu <= 4'd0; r_st <= 4'd0; r_su <= 4'd0; r_t <= 4'd0;
        end else if (w_zero || (w_adv && w_terminal && WRAP)) begin
            r_mt <= 4'd0; r_mu <= 4'd0; r_st <= 4'd0; r_su <= 4'd0; r_t <= 4'd0;
        end else if (w_adv && !w_terminal) begin
            r_t <= w_c0 ? 4'd0 : r_t + 4'd1;
            if (w_c0) r_su <= w_c1 ? 4'd0 : r_su + 4'd1;
            if (w_c1) r_st <= w_c2 ? 4'd0 : r_st + 4'd1;
            if (w_c2) begin
                r_mu <= w_c3 ? 4'd0 : r_mu + 4'd1;
                if (w_c3) r_mt <= r_mt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_ovf <= 1'b0;
        else if (w_zero) r_ovf <= 1'b0;
        else if (w_sat)  r_ovf <= 1'b1;
    end

`ifdef STOPWATCH_LAP_EN
    logic [19:0] r_snap;
    logic        r_frozen;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snap   <= 20'h00000;
            r_frozen <= 1'b0;
        end else if ((r_state == S_RUN) && lap) begin
            if (!r_frozen) r_snap <= w_live;
            r_frozen <= !r_frozen;
        end else if ((r_state != S_RUN) && clear) begin
            r_frozen <= 1'b0;
        end
    end

    always_comb begin
        disp    = r_frozen ? r_snap : w_live;
        frozen  = r_frozen;
        running = r_running;
        ovf     = r_ovf;
    end
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;

    always_comb begin
        disp    = w_live;
        frozen  = 1'b0;
        running = r_running;
        ovf     = r_ovf;
    end
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: wrapping and saturating instances share stimulus, checked against a tenths-count model.
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif
    localparam int LIMIT = 60 * 600 - 1;

    typedef struct packed {
        logic [19:0] disp;
        logic        running;
        logic        ovf;
        logic        frozen;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, tick, start_stop, clear, lap;
    logic [19:0] disp_w, disp_s;
    logic        run_w, run_s, ovf_w, ovf_s, frz_w, frz_s;

    int n_checks = 0;
    int n_fail   = 0;

    int m_st   [2];
    int m_cnt  [2];
    bit m_ovf  [2];
    bit m_frz  [2];
    int m_snap [2];
    exp_t q_w[$];
    exp_t q_s[$];

    always #5 clk = ~clk;

    stopwatch_bcd #(.WRAP(1'b1), .MAX_MIN(59)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp(disp_w), .running(run_w), .ovf(ovf_w), .frozen(frz_w)
    );

    stopwatch_bcd #(.WRAP(1'b0), .MAX_MIN(59)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .disp(disp_s), .running(run_s), .ovf(ovf_s), .frozen(frz_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int c);
        int m, s, t;
        m = c / 600;
        s = (c / 10) % 60;
        t = c % 10;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t)};
    endfunction

    function automatic exp_t model_out(input int d);
        exp_t e;
        e.disp    = m_frz[d] ? to_bcd(m_snap[d]) : to_bcd(m_cnt[d]);
        e.running = (m_st[d] == 1);
        e.ovf     = m_ovf[d];
        e.frozen  = m_frz[d];
        return e;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_frz[d] = 1'b0; m_snap[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit wrap, input bit tk, input bit ss,
                              input bit clr, input bit lp);
        case (m_st[d])
            0: begin
                if (ss) m_st[d] = 1;
                if (clr) m_frz[d] = 1'b0;
            end
            1: begin
                if (LAP && lp) begin
                    if (!m_frz[d]) m_snap[d] = m_cnt[d];
                    m_frz[d] = !m_frz[d];
                end
                if (tk) begin
                    if (m_cnt[d] == LIMIT) begin
                        if (wrap) m_cnt[d] = 0;
                        else begin m_ovf[d] = 1'b1; m_st[d] = 2; end
                    end else begin
                        m_cnt[d]++;
                    end
                end
                if (ss) m_st[d] = 2;
            end
            default: begin
                if (clr) begin
                    m_st[d] = 0; m_cnt[d] = 0; m_ovf[d] = 1'b0; m_frz[d] = 1'b0;
                end else if (ss && !m_ovf[d]) begin
                    m_st[d] = 1;
                end
            end
        endcase
    endtask

    // One clock of stimulus: expectations are queued at drive time and retired after the edge.
    task automatic cyc(input bit tk, input bit ss, input bit clr, input bit lp);
        exp_t ew, es;
        tick = tk; start_stop = ss; clear = clr; lap = lp;
        model_step(0, 1'b1, tk, ss, clr, lp);
        model_step(1, 1'b0, tk, ss, clr, lp);
        q_w.push_back(model_out(0));
        q_s.push_back(model_out(1));
        @(posedge clk);
        #1;
        ew = q_w.pop_front();
        es = q_s.pop_front();
        check_eq("w_disp", 32'(disp_w), 32'(ew.disp));
        check_eq("w_running", 32'(run_w), 32'(ew.running));
        check_eq("w_ovf", 32'(ovf_w), 32'(ew.ovf));
        check_eq("w_frozen", 32'(frz_w), 32'(ew.frozen));
        check_eq("s_disp", 32'(disp_s), 32'(es.disp));
        check_eq("s_running", 32'(run_s), 32'(es.running));
        check_eq("s_ovf", 32'(ovf_s), 32'(es.ovf));
        check_eq("s_frozen", 32'(frz_s), 32'(es.frozen));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        model_reset();
        #2;
        check_eq("rst_disp", 32'(disp_w), 32'h0);
        check_eq("rst_running", 32'(run_w), 32'h0);
        check_eq("rst_ovf", 32'(ovf_s), 32'h0);
        check_eq("rst_frozen", 32'(frz_w), 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Count to 01:23.4 then pull reset between edges.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(834);
        check_eq("pre_rst_disp", 32'(disp_w), 32'h01234);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_disp", 32'(disp_w), 32'h0);
        check_eq("arst_running", 32'(run_w), 32'h0);
        check_eq("arst_ovf", 32'(ovf_w), 32'h0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b1;

        // Idle ignores tick and clear.
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        check_eq("ten_ticks", 32'(disp_w), 32'h00010);
        ticks(600);
        check_eq("610_ticks", 32'(disp_w), 32'h01010);

        // Run up to the terminal value, spot-checking minute carries.
        while (m_cnt[0] < LIMIT) begin
            ticks(1);
            if (m_cnt[0] == 600)  check_eq("roll_0100", 32'(disp_w), 32'h01000);
            if (m_cnt[0] == 6000) check_eq("roll_1000", 32'(disp_w), 32'h10000);
        end
        check_eq("term_w", 32'(disp_w), 32'h59599);
        check_eq("term_s", 32'(disp_s), 32'h59599);
        ticks(1);
        check_eq("wrap_disp", 32'(disp_w), 32'h0);
        check_eq("wrap_running", 32'(run_w), 32'h1);
        check_eq("sat_disp", 32'(disp_s), 32'h59599);
        check_eq("sat_ovf", 32'(ovf_s), 32'h1);
        check_eq("sat_running", 32'(run_s), 32'h0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check_eq("sat_ss_ignored", 32'(run_s), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("sat_clear_disp", 32'(disp_s), 32'h0);
        check_eq("sat_clear_ovf", 32'(ovf_s), 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Tick and start_stop on the same edge at 00:00.4.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(4);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("tick_ss_disp", 32'(disp_w), 32'h00005);
        check_eq("tick_ss_running", 32'(run_w), 32'h0);
        ticks(5);
        check_eq("pause_hold", 32'(disp_w), 32'h00005);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("pause_clear", 32'(disp_w), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("run_clear_ign", 32'(disp_w), 32'h00003);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("clear_wins", 32'(disp_w), 32'h0);
        check_eq("clear_wins_run", 32'(run_w), 32'h0);

        // Lap hold.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(23);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(15);
        if (LAP) begin
            check_eq("lap_hold", 32'(disp_w), 32'h00023);
            check_eq("lap_frozen", 32'(frz_w), 32'h1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("lap_release", 32'(disp_w), 32'h00038);
        check_eq("lap_unfrozen", 32'(frz_w), 32'h0);

        // Sparse random control traffic against the model.
        for (int i = 0; i < 2000; i++)
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 29) == 0), ($urandom_range(0, 24) == 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
